// File: rtl/controle_jogo.sv
// Game sequencer for the VGA renderer: bar, shot and enemy positions, score and round flow.
// Optional build macro ACELERA_EN: enemy speed register that rises every 4th hit.
module controle_jogo #(
  parameter int unsigned LARGURA_TELA  = 640,
  parameter int unsigned ALTURA_TELA   = 480,
  parameter int unsigned LARGURA_BARRA = 64,
  parameter int unsigned ALTURA_BARRA  = 16,
  parameter int unsigned LADO_BOLA     = 8,
  parameter int unsigned VEL_BARRA     = 4,
  parameter int unsigned VEL_TIRO      = 6,
  parameter int unsigned VEL_INIMIGA   = 3
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       btn_esq,
  input  logic       btn_dir,
  input  logic       btn_tiro,
  input  logic       btn_start,
  output logic [9:0] BordaBarraX,
  output logic [9:0] BordaBarraY,
  output logic [9:0] BolaNaveX,
  output logic [9:0] BolaNaveY,
  output logic       BolaNaveAtiva,
  output logic [9:0] BolaInimigaX,
  output logic [9:0] BolaInimigaY,
  output logic       BolaInimigaAtiva,
  output logic       perdeu,
  output logic [7:0] pontos
);

  localparam logic [9:0]  BARRA_X0    = 10'((LARGURA_TELA - LARGURA_BARRA) / 2);
  localparam logic [9:0]  BARRA_XMAX  = 10'(LARGURA_TELA - LARGURA_BARRA);
  localparam logic [9:0]  BARRA_Y     = 10'(ALTURA_TELA - ALTURA_BARRA - LADO_BOLA);
  localparam logic [9:0]  TIRO_DX     = 10'(LARGURA_BARRA / 2 - LADO_BOLA / 2);
  localparam logic [9:0]  TIRO_Y0     = 10'(ALTURA_TELA - ALTURA_BARRA - 2 * LADO_BOLA);
  localparam logic [9:0]  PASSO_BARRA = 10'(VEL_BARRA);
  localparam logic [9:0]  PASSO_TIRO  = 10'(VEL_TIRO);
  localparam logic [9:0]  MARGEM_X    = 10'd64;
  localparam logic [2:0]  VEL0        = 3'(VEL_INIMIGA);
  localparam logic [10:0] LB11        = 11'(LARGURA_BARRA);
  localparam logic [10:0] AB11        = 11'(ALTURA_BARRA);
  localparam logic [10:0] LADO11      = 11'(LADO_BOLA);
  localparam logic [10:0] ALT11       = 11'(ALTURA_TELA);

  typedef enum logic [1:0] {
    ESPERA  = 2'd0,
    JOGANDO = 2'd1,
    PERDEU  = 2'd2
  } estado_t;

  estado_t     estado_q, estado_d;
  logic [9:0]  barra_x_q, barra_x_d;
  logic [9:0]  tiro_x_q, tiro_x_d, tiro_y_q, tiro_y_d;
  logic        tiro_ativo_q, tiro_ativo_d;
  logic [9:0]  ini_x_q, ini_x_d, ini_y_q, ini_y_d;
  logic        ini_ativo_q, ini_ativo_d;
  logic [7:0]  pontos_q, pontos_d;
  logic [9:0]  lfsr_q, lfsr_d;
  logic [2:0]  vel;
`ifdef ACELERA_EN
  logic [2:0]  vel_q, vel_d;
  assign vel = vel_q;
`else
  assign vel = VEL0;
`endif

  logic [10:0] bx, by, tx, ty, ix, iy, v11;
  logic        perda, acerto, ini_fora;
  logic [9:0]  spawn_x;

  assign bx  = {1'b0, barra_x_q};
  assign by  = {1'b0, BARRA_Y};
  assign tx  = {1'b0, tiro_x_q};
  assign ty  = {1'b0, tiro_y_q};
  assign ix  = {1'b0, ini_x_q};
  assign iy  = {1'b0, ini_y_q};
  assign v11 = {8'd0, vel};

  // Strict AABB tests on pre-edge registers, widened so sums cannot wrap
  assign perda    = ini_ativo_q && (ix < bx + LB11) && (bx < ix + LADO11) &&
                    (iy < by + AB11) && (by < iy + LADO11);
  assign acerto   = tiro_ativo_q && ini_ativo_q && (ix < tx + LADO11) && (tx < ix + LADO11) &&
                    (iy < ty + LADO11) && (ty < iy + LADO11);
  assign ini_fora = (iy + LADO11 + v11) >= ALT11;
  assign spawn_x  = {1'b0, lfsr_q[8:0]} + MARGEM_X;

  always_ff @(posedge CLOCK_50) begin
    if (reset) estado_q <= ESPERA;
    else       estado_q <= estado_d;
  end

  always_comb begin
    estado_d = estado_q;
    case (estado_q)
      ESPERA:  if (btn_start) estado_d = JOGANDO;
      JOGANDO: if (frame_tick && perda) estado_d = PERDEU;
      PERDEU:  if (btn_start) estado_d = ESPERA;
      default: estado_d = ESPERA;
    endcase
  end

  always_comb begin
    barra_x_d    = barra_x_q;
    tiro_x_d     = tiro_x_q;
    tiro_y_d     = tiro_y_q;
    tiro_ativo_d = tiro_ativo_q;
    ini_x_d      = ini_x_q;
    ini_y_d      = ini_y_q;
    ini_ativo_d  = ini_ativo_q;
    pontos_d     = pontos_q;
    lfsr_d       = {lfsr_q[8:0], lfsr_q[9] ^ lfsr_q[6]};
`ifdef ACELERA_EN
    vel_d        = vel_q;
`endif
    case (estado_q)
      ESPERA: begin
        if (btn_start) begin
          ini_x_d     = spawn_x;
          ini_y_d     = '0;
          ini_ativo_d = 1'b1;
        end
      end
      JOGANDO: begin
        // A losing frame changes nothing: everything stays as the loss was seen
        if (frame_tick && !perda) begin
          if (btn_esq && !btn_dir)
            barra_x_d = (barra_x_q < PASSO_BARRA) ? '0 : barra_x_q - PASSO_BARRA;
          else if (btn_dir && !btn_esq)
            barra_x_d = (barra_x_q > BARRA_XMAX - PASSO_BARRA) ? BARRA_XMAX : barra_x_q + PASSO_BARRA;
          if (acerto || (tiro_ativo_q && tiro_y_q < PASSO_TIRO)) begin
            tiro_ativo_d = 1'b0;
            tiro_x_d     = '0;
            tiro_y_d     = '0;
          end else if (tiro_ativo_q) begin
            tiro_y_d = tiro_y_q - PASSO_TIRO;
          end else if (btn_tiro) begin
            tiro_ativo_d = 1'b1;
            tiro_x_d     = barra_x_q + TIRO_DX;
            tiro_y_d     = TIRO_Y0;
          end
          if (acerto || ini_fora) begin
            ini_x_d = spawn_x;
            ini_y_d = '0;
          end else begin
            ini_y_d = ini_y_q + {7'd0, vel};
          end
          if (acerto && pontos_q != '1) begin
            pontos_d = pontos_q + 8'd1;
`ifdef ACELERA_EN
            if (pontos_d[1:0] == 2'b00 && vel_q != '1) vel_d = vel_q + 3'd1;
`endif
          end
        end
      end
      default: begin
        // Leaving PERDEU (or recovering from a bad encoding) restores all but the LFSR
        if (btn_start || estado_q != PERDEU) begin
          barra_x_d    = BARRA_X0;
          tiro_x_d     = '0;
          tiro_y_d     = '0;
          tiro_ativo_d = 1'b0;
          ini_x_d      = '0;
          ini_y_d      = '0;
          ini_ativo_d  = 1'b0;
          pontos_d     = '0;
`ifdef ACELERA_EN
          vel_d        = VEL0;
`endif
        end
      end
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      barra_x_q    <= BARRA_X0;
      tiro_x_q     <= '0;
      tiro_y_q     <= '0;
      tiro_ativo_q <= 1'b0;
      ini_x_q      <= '0;
      ini_y_q      <= '0;
      ini_ativo_q  <= 1'b0;
      pontos_q     <= '0;
      lfsr_q       <= 10'h001;
`ifdef ACELERA_EN
      vel_q        <= VEL0;
`endif
    end else begin
      barra_x_q    <= barra_x_d;
      tiro_x_q     <= tiro_x_d;
      tiro_y_q     <= tiro_y_d;
      tiro_ativo_q <= tiro_ativo_d;
      ini_x_q      <= ini_x_d;
      ini_y_q      <= ini_y_d;
      ini_ativo_q  <= ini_ativo_d;
      pontos_q     <= pontos_d;
      lfsr_q       <= lfsr_d;
`ifdef ACELERA_EN
      vel_q        <= vel_d;
`endif
    end
  end

  always_comb begin
    BordaBarraX      = barra_x_q;
    BordaBarraY      = BARRA_Y;
    BolaNaveX        = tiro_x_q;
    BolaNaveY        = tiro_y_q;
    BolaNaveAtiva    = tiro_ativo_q;
    BolaInimigaX     = ini_x_q;
    BolaInimigaY     = ini_y_q;
    BolaInimigaAtiva = ini_ativo_q;
    perdeu           = (estado_q == PERDEU);
    pontos           = pontos_q;
  end

endmodule

// File: tb/tb_controle_jogo.sv
// Directed bench for controle_jogo; enemy spawn X is steered by timing btn_start against an LFSR model.
module tb_controle_jogo;

  logic       clk = 1'b0;
  logic       reset, frame_tick, btn_esq, btn_dir, btn_tiro, btn_start;
  logic [9:0] BordaBarraX, BordaBarraY, BolaNaveX, BolaNaveY, BolaInimigaX, BolaInimigaY;
  logic       BolaNaveAtiva, BolaInimigaAtiva, perdeu;
  logic [7:0] pontos;

  int checks = 0;
  int failures = 0;
  logic [9:0] tb_lfsr;
  logic [9:0] lfsr_tick;

  localparam logic [70:0] RST_VEC = {10'd288, 10'd456, 1'b0, 10'd0, 10'd0, 1'b0, 10'd0, 10'd0, 1'b0, 8'd0};
  logic [70:0] obs_all;
  logic [20:0] tiro_v, ini_v;
  assign obs_all = {BordaBarraX, BordaBarraY, BolaNaveAtiva, BolaNaveX, BolaNaveY,
                    BolaInimigaAtiva, BolaInimigaX, BolaInimigaY, perdeu, pontos};
  assign tiro_v  = {BolaNaveAtiva, BolaNaveX, BolaNaveY};
  assign ini_v   = {BolaInimigaAtiva, BolaInimigaX, BolaInimigaY};

  controle_jogo dut (
    .CLOCK_50(clk), .reset(reset), .frame_tick(frame_tick),
    .btn_esq(btn_esq), .btn_dir(btn_dir), .btn_tiro(btn_tiro), .btn_start(btn_start),
    .BordaBarraX(BordaBarraX), .BordaBarraY(BordaBarraY),
    .BolaNaveX(BolaNaveX), .BolaNaveY(BolaNaveY), .BolaNaveAtiva(BolaNaveAtiva),
    .BolaInimigaX(BolaInimigaX), .BolaInimigaY(BolaInimigaY), .BolaInimigaAtiva(BolaInimigaAtiva),
    .perdeu(perdeu), .pontos(pontos)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (reset) tb_lfsr <= 10'h001;
    else       tb_lfsr <= {tb_lfsr[8:0], tb_lfsr[9] ^ tb_lfsr[6]};
  end

  task automatic do_reset();
    reset = 1'b1; frame_tick = 1'b0; btn_esq = 1'b0; btn_dir = 1'b0; btn_tiro = 1'b0; btn_start = 1'b0;
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic tick();
    lfsr_tick = tb_lfsr;
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    @(negedge clk);
  endtask

  task automatic start_round(input logic [8:0] target);
    int unsigned n = 0;
    logic [20:0] e;
    while (tb_lfsr[8:0] !== target && n < 2100) begin
      @(negedge clk);
      n++;
    end
    if (tb_lfsr[8:0] !== target) begin
      checks++; failures++;
      $display("FAIL start_wait lfsr=%h want_low9=%h", tb_lfsr, target);
    end
    btn_start = 1'b1;
    @(negedge clk);
    btn_start = 1'b0;
    e = {1'b1, {1'b0, target} + 10'd64, 10'd0};
    checks++;
    if (ini_v !== e || perdeu !== 1'b0 || BordaBarraX !== 10'd288) begin
      failures++;
      $display("FAIL round_start enemy=%h bar=%0d perdeu=%b want enemy=%h bar=288 perdeu=0", ini_v, BordaBarraX, perdeu, e);
    end
  endtask

  task automatic test_reset();
    logic [9:0] ex;
    do_reset();
    checks++;
    if (obs_all !== RST_VEC) begin failures++; $display("FAIL reset_vals got=%h want=%h", obs_all, RST_VEC); end
    btn_dir = 1'b1; btn_tiro = 1'b1;
    tick();
    btn_dir = 1'b0; btn_tiro = 1'b0;
    checks++;
    if (obs_all !== RST_VEC) begin failures++; $display("FAIL espera_hold got=%h want=%h", obs_all, RST_VEC); end
    ex = {1'b0, tb_lfsr[8:0]} + 10'd64;
    btn_start = 1'b1;
    @(negedge clk);
    btn_start = 1'b0;
    checks++;
    if (ini_v !== {1'b1, ex, 10'd0} || BordaBarraX !== 10'd288 || perdeu !== 1'b0) begin
      failures++;
      $display("FAIL start_spawn enemy=%h bar=%0d perdeu=%b want enemy=%h bar=288 perdeu=0", ini_v, BordaBarraX, perdeu, {1'b1, ex, 10'd0});
    end
  endtask

  task automatic test_bar_dir();
    do_reset();
    start_round(9'd0);
    btn_dir = 1'b1;
    tick();
    checks++;
    if (BordaBarraX !== 10'd292) begin failures++; $display("FAIL bar_dir_step got=%0d want=292", BordaBarraX); end
    for (int i = 0; i < 71; i++) tick();
    checks++;
    if (BordaBarraX !== 10'd576) begin failures++; $display("FAIL bar_dir_edge got=%0d want=576", BordaBarraX); end
    for (int i = 0; i < 78; i++) tick();
    btn_dir = 1'b0;
    checks++;
    if (BordaBarraX !== 10'd576 || BolaInimigaY !== 10'd450 || perdeu !== 1'b0) begin
      failures++;
      $display("FAIL bar_dir_clamp bar=%0d eY=%0d perdeu=%b want 576 450 0", BordaBarraX, BolaInimigaY, perdeu);
    end
  endtask

  task automatic test_bar_esq();
    do_reset();
    start_round(9'h1FF);
    btn_esq = 1'b1; btn_dir = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    checks++;
    if (BordaBarraX !== 10'd288) begin failures++; $display("FAIL bar_both got=%0d want=288", BordaBarraX); end
    btn_dir = 1'b0;
    tick();
    checks++;
    if (BordaBarraX !== 10'd284) begin failures++; $display("FAIL bar_esq_step got=%0d want=284", BordaBarraX); end
    for (int i = 0; i < 149; i++) tick();
    btn_esq = 1'b0;
    checks++;
    if (BordaBarraX !== 10'd0 || BolaInimigaY !== 10'd459 || perdeu !== 1'b0) begin
      failures++;
      $display("FAIL bar_esq_clamp bar=%0d eY=%0d perdeu=%b want 0 459 0", BordaBarraX, BolaInimigaY, perdeu);
    end
  endtask

  task automatic test_shot_and_reset_mid();
    do_reset();
    start_round(9'h1FF);
    btn_tiro = 1'b1;
    tick();
    checks++;
    if (tiro_v !== {1'b1, 10'd316, 10'd448}) begin failures++; $display("FAIL shot_spawn got=%h want=%h", tiro_v, {1'b1, 10'd316, 10'd448}); end
    tick();
    checks++;
    if (tiro_v !== {1'b1, 10'd316, 10'd442}) begin failures++; $display("FAIL shot_rise got=%h want=%h", tiro_v, {1'b1, 10'd316, 10'd442}); end
    for (int i = 0; i < 73; i++) tick();
    checks++;
    if (tiro_v !== {1'b1, 10'd316, 10'd4}) begin failures++; $display("FAIL shot_low got=%h want=%h", tiro_v, {1'b1, 10'd316, 10'd4}); end
    tick();
    checks++;
    if (tiro_v !== 21'd0) begin failures++; $display("FAIL shot_die got=%h want=0", tiro_v); end
    tick();
    checks++;
    if (tiro_v !== {1'b1, 10'd316, 10'd448} || BolaInimigaY !== 10'd231) begin
      failures++;
      $display("FAIL shot_refire shot=%h eY=%0d want shot=%h eY=231", tiro_v, BolaInimigaY, {1'b1, 10'd316, 10'd448});
    end
    reset = 1'b1; frame_tick = 1'b1; btn_dir = 1'b1;
    @(negedge clk);
    reset = 1'b0; frame_tick = 1'b0; btn_dir = 1'b0; btn_tiro = 1'b0;
    checks++;
    if (obs_all !== RST_VEC) begin failures++; $display("FAIL reset_mid got=%h want=%h", obs_all, RST_VEC); end
  endtask

  task automatic test_hit_then_loss();
    logic [9:0] ex, cur, tgt;
    do_reset();
    start_round(9'd252);
    btn_tiro = 1'b1;
    tick();
    btn_tiro = 1'b0;
    for (int i = 0; i < 49; i++) tick();
    checks++;
    if (BolaInimigaY !== 10'd150 || tiro_v !== {1'b1, 10'd316, 10'd154} || pontos !== 8'd0) begin
      failures++;
      $display("FAIL pre_hit eY=%0d shot=%h pontos=%0d want 150 %h 0", BolaInimigaY, tiro_v, pontos, {1'b1, 10'd316, 10'd154});
    end
    tick();
    ex = {1'b0, lfsr_tick[8:0]} + 10'd64;
    checks++;
    if (pontos !== 8'd1 || tiro_v !== 21'd0 || ini_v !== {1'b1, ex, 10'd0}) begin
      failures++;
      $display("FAIL hit pontos=%0d shot=%h enemy=%h want 1 0 %h", pontos, tiro_v, ini_v, {1'b1, ex, 10'd0});
    end
    cur = 10'd288;
    tgt = (ex - 10'd28) & ~10'd3;
    for (int i = 0; i < 150; i++) begin
      btn_dir = (cur < tgt);
      btn_esq = (cur > tgt);
      tick();
      if (cur < tgt) cur = cur + 10'd4;
      else if (cur > tgt) cur = cur - 10'd4;
    end
    btn_dir = 1'b0; btn_esq = 1'b0;
    checks++;
    if (BordaBarraX !== tgt || BolaInimigaY !== 10'd450 || perdeu !== 1'b0) begin
      failures++;
      $display("FAIL pre_loss bar=%0d eY=%0d perdeu=%b want %0d 450 0", BordaBarraX, BolaInimigaY, perdeu, tgt);
    end
    btn_dir = 1'b1;
    tick();
    checks++;
    if (perdeu !== 1'b1 || ini_v !== {1'b1, ex, 10'd450} || BordaBarraX !== tgt || pontos !== 8'd1) begin
      failures++;
      $display("FAIL loss perdeu=%b enemy=%h bar=%0d pontos=%0d want 1 %h %0d 1", perdeu, ini_v, BordaBarraX, pontos, {1'b1, ex, 10'd450}, tgt);
    end
    btn_tiro = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    btn_dir = 1'b0; btn_tiro = 1'b0;
    checks++;
    if (perdeu !== 1'b1 || ini_v !== {1'b1, ex, 10'd450} || BordaBarraX !== tgt || tiro_v !== 21'd0) begin
      failures++;
      $display("FAIL frozen perdeu=%b enemy=%h bar=%0d shot=%h want 1 %h %0d 0", perdeu, ini_v, BordaBarraX, tiro_v, {1'b1, ex, 10'd450}, tgt);
    end
    btn_start = 1'b1;
    @(negedge clk);
    checks++;
    if (obs_all !== RST_VEC) begin failures++; $display("FAIL restart_espera got=%h want=%h", obs_all, RST_VEC); end
    ex = {1'b0, tb_lfsr[8:0]} + 10'd64;
    @(negedge clk);
    btn_start = 1'b0;
    checks++;
    if (ini_v !== {1'b1, ex, 10'd0} || perdeu !== 1'b0) begin
      failures++;
      $display("FAIL restart_round enemy=%h perdeu=%b want %h 0", ini_v, perdeu, {1'b1, ex, 10'd0});
    end
  endtask

  task automatic test_hit_and_loss();
    do_reset();
    start_round(9'd252);
    for (int i = 0; i < 149; i++) tick();
    btn_tiro = 1'b1;
    tick();
    btn_tiro = 1'b0;
    checks++;
    if (tiro_v !== {1'b1, 10'd316, 10'd448} || BolaInimigaY !== 10'd450 || perdeu !== 1'b0) begin
      failures++;
      $display("FAIL both_pre shot=%h eY=%0d perdeu=%b want %h 450 0", tiro_v, BolaInimigaY, perdeu, {1'b1, 10'd316, 10'd448});
    end
    tick();
    checks++;
    if (perdeu !== 1'b1 || pontos !== 8'd0 || tiro_v !== {1'b1, 10'd316, 10'd448} || ini_v !== {1'b1, 10'd316, 10'd450}) begin
      failures++;
      $display("FAIL both_same_tick perdeu=%b pontos=%0d shot=%h enemy=%h want 1 0 %h %h",
               perdeu, pontos, tiro_v, ini_v, {1'b1, 10'd316, 10'd448}, {1'b1, 10'd316, 10'd450});
    end
  endtask

  initial begin
    reset = 1'b1; frame_tick = 1'b0; btn_esq = 1'b0; btn_dir = 1'b0; btn_tiro = 1'b0; btn_start = 1'b0;
    test_reset();
    test_bar_dir();
    test_bar_esq();
    test_shot_and_reset_mid();
    test_hit_then_loss();
    test_hit_and_loss();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
